fifo_sync_stream_reader: RTL
============================

Name: fifo_sync_stream_reader

Overview:
- Downstream stage of the synchronous FIFO. Drains the FIFO's read port and presents the words as a valid/ready stream to consumers such as cache fill paths and engine input lanes.
- The FIFO returns read data one cycle after an accepted read, so this block prefetches into a small circular buffer. This sustains one word per cycle.
- No combinational path exists from m_ready to fifo_r_en.

Parameters:
- DATA_W, 32, word width; must equal the FIFO R_DATA_W.
- DEPTH, 3, prefetch buffer entries; legal range 3..16. 3 is the minimum for full throughput.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; discards buffered and in-flight words.
- fifo_r_en  out  1  FIFO read request.
- fifo_r_data  in  DATA_W  FIFO read data, valid the cycle after an accepted read.
- fifo_r_empty  in  1  FIFO empty flag (registered in the FIFO).
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATA_W  output word, head of the buffer.
- occupancy  out  CNT_W  buffered words plus in-flight reads.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - Buffer pointers, count and inflight are cleared.
  - m_valid=0, occupancy=0, fifo_r_en=0. fifo_r_en is forced low while ap_rst_n is low.
  - m_data content is don't-care while m_valid=0.
- Accepted read: acc = fifo_r_en & ~fifo_r_empty.
- Issue rule (combinational from registered state only):
  - fifo_r_en = ~fifo_r_empty & ~flush & ((count + inflight) < DEPTH).
- inflight is a 1-bit register, loaded with acc every cycle.
- Return: when inflight=1, fifo_r_data is written at wr_ptr in that cycle. wr_ptr increments and wraps DEPTH-1 -> 0.
- Output:
  - m_valid = (count != 0).
  - m_data = buf[rd_ptr]; it is a register read, not a FIFO passthrough, so there is 1 cycle minimum latency from return to m_valid.
  - Pop when m_valid & m_ready. rd_ptr increments and wraps.
- Count arithmetic:
  - count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
  - count never exceeds DEPTH; the issue rule guarantees this.
- Handshake: once m_valid=1, m_data stays stable until popped or flushed. m_valid never drops without a pop except on flush or reset.
- Throughput: with a continuously non-empty FIFO and m_ready=1, steady state is one word per cycle.
  - Startup latency: first fifo_r_en at cycle 0, data into the buffer at the end of cycle 1, m_valid=1 in cycle 2.
- Backpressure: with m_ready=0, reads stop once count + inflight = DEPTH. No word is lost or duplicated.
- Flush (synchronous):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, inflight=0, m_valid=0.
  - A return arriving in the flush cycle is discarded.
  - fifo_r_en=0 during the flush cycle.
  - A pop in the flush cycle is ignored and the word is lost.
  - The FIFO itself is not drained.
- Empty FIFO: fifo_r_en=0 and no state change except pops.
- occupancy = count + inflight, registered view (current-cycle values).

Test Plan:
- Reset then write 0x11,0x22,0x33 into the FIFO, m_ready=1 -> m_valid rises 2 cycles after the first fifo_r_en; m_data is 0x11,0x22,0x33 on consecutive cycles; m_valid then drops and occupancy=0.
- Stream 64 words, m_ready held 1 -> 64 handshakes in 64 consecutive cycles after the first m_valid, in order, no gaps.
- 10 words queued, m_ready=0 for 20 cycles -> exactly 3 fifo_r_en accepts; occupancy=3; m_data=word0 stable. Release m_ready -> remaining words are delivered in order and wrap-around is exercised.
- m_ready toggled randomly 50% over 200 words -> scoreboard matches, no loss or duplicate, m_data stable while m_valid & ~m_ready.
- Assert flush while count=2 and inflight=1 -> next cycle m_valid=0 and occupancy=0. The next FIFO word (e.g. 0x44) is the first delivered after flush.
- Drop ap_rst_n mid-stream with count=3 -> m_valid=0 and fifo_r_en=0 immediately. After release, the block behaves as from initial reset.

Source files
------------

// File: rtl/fifo_sync_stream_reader.sv
// Prefetching read-side adapter: drains a synchronous FIFO (1-cycle read latency)
// into a small circular buffer and presents the words as a valid/ready stream.
module fifo_sync_stream_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              flush,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_r_data,
  input  logic              fifo_r_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_q [DEPTH];

  logic [SUM_W-1:0]  pending;
  logic              issue_ok;
  logic              acc;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue decision uses registered state only, so m_ready never reaches fifo_r_en.
  assign pending   = SUM_W'(count_q) + SUM_W'(inflight_q);
  assign issue_ok  = (pending < SUM_W'(DEPTH));
  assign fifo_r_en = ap_rst_n & ~fifo_r_empty & ~flush & issue_ok;
  assign acc       = fifo_r_en & ~fifo_r_empty;

  // A return or a pop coinciding with flush is dropped.
  assign push = inflight_q & ~flush;
  assign pop  = m_valid & m_ready & ~flush;

  assign m_valid   = (count_q != '0);
  assign m_data    = buf_q[rd_ptr_q];
  assign occupancy = count_q + CNT_W'(inflight_q);

  always_comb begin
    count_d    = count_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (flush) begin
      count_d    = '0;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      inflight_d = acc;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; m_valid qualifies it.
  always_ff @(posedge ap_clk) begin
    if (push) buf_q[wr_ptr_q] <= fifo_r_data;
  end

endmodule
